control_sequencer: RTL and testbench
====================================

# control_sequencer

Multi-cycle control unit for the MiniSRC processor datapath. It takes the latched instruction word from the IR, the ALU zero flag and two memory-ready handshakes. From these it drives every enable, mux select, ALU opcode and memory strobe the datapath consumes. It sits directly upstream of the datapath and replaces the hand-driven control signals used so far.

## Interface
- No parameters.
- iClk  in  1  system clock, all state updates on rising edge
- nRst  in  1  asynchronous active-low reset
- ir  in  32  IR contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15], C ir[18:0]
- alu_zero_flag  in  1  ALU zero output
- iInstrReady  in  1  instruction memory has valid data this cycle
- iMemReady  in  1  data memory read data valid / write accepted this cycle
- ir_enable, ra_enable, rb_enable, rz0_enable, rz1_enable, rm_enable, ry_enable, rpc_enable, rpc_temp_enable  out  1 each  register load enables
- mb_select, minc_select, mpc_select  out  1 each  0 = RB / +4 / RA; 1 = immediate / C / PC adder
- my_select  out  2  0 RZ0, 1 RZ1, 2 memory data, 3 return address
- mc_select  out  2  write address: 0 Rb field, 1 Rc field, 2 link register R15
- rf_write  out  1  register file write
- alu_control  out  4  0 add, 1 sub, 2 or, 3 and, 4 div, 5 mul
- mem_read, mem_write, instruction_mem_read  out  1 each  memory strobes
- oHalted  out  1  core stopped
- oFault  out  1  illegal opcode seen

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, HALT.
- FETCH: assert instruction_mem_read and hold until iInstrReady. On the ready cycle, pulse ir_enable and also rpc_enable with mpc_select=1, minc_select=0 (PC+4). Then go to DECODE.
- DECODE: ra_enable, rb_enable, rpc_temp_enable (captures PC+4). NOP goes to FETCH. HALT goes to HALT. An illegal opcode goes to HALT and sets oFault. Everything else goes to EXEC.
- EXEC by class:
  - R-type (ADD 00011, SUB 00100, AND 00101, OR 00110, MUL 01111, DIV 10000): Rc <- Ra op Rb. mb_select=0, rz0_enable and rz1_enable, alu_control from opcode.
  - ADDI 01100, LD 00000, ST 00010: mb_select=1, add, rz0_enable. ST also asserts rm_enable.
  - BEQ 10011: sub with mb_select=0. Latch alu_zero_flag into the internal taken flop. Go to BRANCH.
  - JR 10100: rpc_enable, mpc_select=0. Go to FETCH.
  - JAL 10101: same as JR, then go to MEM.
- MEM:
  - R-type and ADDI: ry_enable, my_select=0.
  - LD: hold mem_read until iMemReady, then ry_enable with my_select=2.
  - ST: hold mem_write until iMemReady, then go to FETCH.
  - JAL: ry_enable, my_select=3.
- WB: rf_write. mc_select is 1 for R-type, 0 for ADDI/LD, 2 for JAL. Then go to FETCH.
- BRANCH: if taken, rpc_enable with mpc_select=1, minc_select=1. Then go to FETCH.
- HALT: every enable and strobe is 0 and oHalted=1. Only reset leaves HALT.
- Outputs not listed for a state are 0. alu_control defaults to 0.

## Timing
- Moore outputs: combinational decode of the state register and ir. No output depends on a ready input, except that the load pulse occurs only in the ready cycle.
- Reset: asynchronous entry to FETCH. Taken, oFault and oHalted clear to 0. All outputs read 0 while nRst is low. instruction_mem_read rises combinationally after release.
- Zero-wait cycle counts: R-type/ADDI/LD/JAL 5, ST/BEQ 4, JR 3, NOP 2.
- Each wait cycle adds exactly one cycle. A strobe stays high continuously until its ready signal arrives.
- Ready asserted in the first strobe cycle is accepted that cycle.
- A ready input outside its waiting state is ignored.
- mem_read and mem_write are never high together.
- Reset mid-wait abandons the request. The strobe drops in the same cycle as nRst falls.

## Structure
- Package minisrc_pkg holds:
  - the opcode constants above, ALU code constants, my/mc select constants;
  - the state enum;
  - a function giving the instruction class from the opcode.
- A single sub-module is natural: instr_decode, combinational, mapping the opcode to class, alu_control and the illegal flag.

## Test plan
- ADD (ir=0x18998000), ready always 1 → exactly 5 cycles. WB shows rf_write=1, mc_select=1. Next cycle is FETCH.
- LD with iMemReady low for 3 MEM cycles → mem_read high 4 cycles. ry_enable pulses once with my_select=2. Total 8 cycles.
- BEQ with alu_zero_flag=1, then again with 0 → BRANCH rpc_enable=1 with minc_select=1, versus rpc_enable=0.
- JAL → EXEC mpc_select=0 with rpc_enable. MEM my_select=3. WB mc_select=2 with rf_write.
- Opcode 11111 → HALT in DECODE, oFault=1 and oHalted=1, all strobes 0 for 20 cycles.
- nRst pulled low during ST wait → mem_write drops immediately. After release, FETCH is entered and instruction_mem_read=1.

Source files
------------

// File: rtl/minisrc_pkg.sv
// Shared MiniSRC control definitions: opcodes, ALU codes, datapath select codes,
// sequencer states and the opcode-to-instruction-class mapping.
package minisrc_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BEQ  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_OR  = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_DIV = 4'd4;
    localparam logic [3:0] ALU_MUL = 4'd5;

    localparam logic [1:0] MY_RZ0  = 2'd0;
    localparam logic [1:0] MY_RZ1  = 2'd1;
    localparam logic [1:0] MY_MEM  = 2'd2;
    localparam logic [1:0] MY_RET  = 2'd3;

    localparam logic [1:0] MC_RB   = 2'd0;
    localparam logic [1:0] MC_RC   = 2'd1;
    localparam logic [1:0] MC_LINK = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_RTYPE, C_IMM, C_LD, C_ST, C_BEQ, C_JR, C_JAL, C_NOP, C_HALT, C_ILLEGAL
    } iclass_t;

    function automatic iclass_t class_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: return C_RTYPE;
            OP_ADDI: return C_IMM;
            OP_LD:   return C_LD;
            OP_ST:   return C_ST;
            OP_BEQ:  return C_BEQ;
            OP_JR:   return C_JR;
            OP_JAL:  return C_JAL;
            OP_NOP:  return C_NOP;
            OP_HALT: return C_HALT;
            default: return C_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer (master) and the MiniSRC datapath (slave):
// IR word, ALU flag, memory ready handshakes and every datapath control line.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        alu_zero_flag;
    logic        iInstrReady;
    logic        iMemReady;

    logic        ir_enable, ra_enable, rb_enable, rz0_enable, rz1_enable;
    logic        rm_enable, ry_enable, rpc_enable, rpc_temp_enable;
    logic        mb_select, minc_select, mpc_select;
    logic [1:0]  my_select;
    logic [1:0]  mc_select;
    logic        rf_write;
    logic [3:0]  alu_control;
    logic        mem_read, mem_write, instruction_mem_read;
    logic        oHalted, oFault;

    modport master (
        input  ir, alu_zero_flag, iInstrReady, iMemReady,
        output ir_enable, ra_enable, rb_enable, rz0_enable, rz1_enable,
               rm_enable, ry_enable, rpc_enable, rpc_temp_enable,
               mb_select, minc_select, mpc_select, my_select, mc_select,
               rf_write, alu_control, mem_read, mem_write, instruction_mem_read,
               oHalted, oFault
    );

    modport slave (
        output ir, alu_zero_flag, iInstrReady, iMemReady,
        input  ir_enable, ra_enable, rb_enable, rz0_enable, rz1_enable,
               rm_enable, ry_enable, rpc_enable, rpc_temp_enable,
               mb_select, minc_select, mpc_select, my_select, mc_select,
               rf_write, alu_control, mem_read, mem_write, instruction_mem_read,
               oHalted, oFault
    );
endinterface

// File: rtl/control_sequencer_instr_decode.sv
// Combinational opcode decode: instruction class, ALU operation and illegal flag.
// Zero latency; no handshake.
module instr_decode
    import minisrc_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    iclass,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        iclass  = class_of(opcode);
        illegal = (iclass == C_ILLEGAL);
        // BEQ compares by subtraction; loads, stores and ADDI form addresses with add
        case (opcode)
            OP_SUB, OP_BEQ: alu_control = ALU_SUB;
            OP_OR:          alu_control = ALU_OR;
            OP_AND:         alu_control = ALU_AND;
            OP_DIV:         alu_control = ALU_DIV;
            OP_MUL:         alu_control = ALU_MUL;
            default:        alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle MiniSRC control unit: Moore decode of state and IR into datapath controls.
// 2-5 cycles per instruction plus one per wait cycle; strobes hold until their ready arrives.
module control_sequencer
    import minisrc_pkg::*;
(
    input  logic                iClk,
    input  logic                nRst,
    control_sequencer_if.master bus
);

    state_t     state;
    logic       taken;
    logic       fault;
    iclass_t    iclass;
    logic [3:0] dec_alu;
    logic       dec_illegal;

    instr_decode u_decode (
        .opcode      (bus.ir[31:27]),
        .iclass      (iclass),
        .alu_control (dec_alu),
        .illegal     (dec_illegal)
    );

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state <= S_FETCH;
            taken <= 1'b0;
            fault <= 1'b0;
        end else begin
            case (state)
                S_FETCH:  if (bus.iInstrReady) state <= S_DECODE;
                S_DECODE: begin
                    if (dec_illegal) begin
                        fault <= 1'b1;
                        state <= S_HALT;
                    end else begin
                        case (iclass)
                            C_NOP:   state <= S_FETCH;
                            C_HALT:  state <= S_HALT;
                            default: state <= S_EXEC;
                        endcase
                    end
                end
                S_EXEC: begin
                    case (iclass)
                        C_BEQ: begin
                            taken <= bus.alu_zero_flag;
                            state <= S_BRANCH;
                        end
                        C_JR:    state <= S_FETCH;
                        default: state <= S_MEM;
                    endcase
                end
                S_MEM: begin
                    case (iclass)
                        C_LD:    if (bus.iMemReady) state <= S_WB;
                        C_ST:    if (bus.iMemReady) state <= S_FETCH;
                        default: state <= S_WB;
                    endcase
                end
                S_WB:     state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_FETCH;
            endcase
        end
    end

    // Gating with nRst keeps every output low during reset, although the state already reads FETCH.
    always_comb begin
        bus.ir_enable            = 1'b0;
        bus.ra_enable            = 1'b0;
        bus.rb_enable            = 1'b0;
        bus.rz0_enable           = 1'b0;
        bus.rz1_enable           = 1'b0;
        bus.rm_enable            = 1'b0;
        bus.ry_enable            = 1'b0;
        bus.rpc_enable           = 1'b0;
        bus.rpc_temp_enable      = 1'b0;
        bus.mb_select            = 1'b0;
        bus.minc_select          = 1'b0;
        bus.mpc_select           = 1'b0;
        bus.my_select            = MY_RZ0;
        bus.mc_select            = MC_RB;
        bus.rf_write             = 1'b0;
        bus.alu_control          = ALU_ADD;
        bus.mem_read             = 1'b0;
        bus.mem_write            = 1'b0;
        bus.instruction_mem_read = 1'b0;
        bus.oHalted              = 1'b0;
        bus.oFault               = 1'b0;
        if (nRst) begin
            bus.oFault = fault;
            case (state)
                S_FETCH: begin
                    bus.instruction_mem_read = 1'b1;
                    bus.mpc_select           = 1'b1;
                    bus.ir_enable            = bus.iInstrReady;
                    bus.rpc_enable           = bus.iInstrReady;
                end
                S_DECODE: begin
                    bus.ra_enable       = 1'b1;
                    bus.rb_enable       = 1'b1;
                    bus.rpc_temp_enable = 1'b1;
                end
                S_EXEC: begin
                    bus.alu_control = dec_alu;
                    case (iclass)
                        C_RTYPE: begin
                            bus.rz0_enable = 1'b1;
                            bus.rz1_enable = 1'b1;
                        end
                        C_IMM, C_LD, C_ST: begin
                            bus.mb_select  = 1'b1;
                            bus.rz0_enable = 1'b1;
                            bus.rm_enable  = (iclass == C_ST);
                        end
                        C_JR, C_JAL: bus.rpc_enable = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    case (iclass)
                        C_RTYPE, C_IMM: bus.ry_enable = 1'b1;
                        C_LD: begin
                            bus.mem_read  = 1'b1;
                            bus.my_select = MY_MEM;
                            bus.ry_enable = bus.iMemReady;
                        end
                        C_ST: bus.mem_write = 1'b1;
                        C_JAL: begin
                            bus.ry_enable = 1'b1;
                            bus.my_select = MY_RET;
                        end
                        default: ;
                    endcase
                end
                S_WB: begin
                    bus.rf_write  = 1'b1;
                    bus.mc_select = (iclass == C_RTYPE) ? MC_RC :
                                    (iclass == C_JAL)   ? MC_LINK : MC_RB;
                end
                S_BRANCH: begin
                    bus.rpc_enable  = taken;
                    bus.mpc_select  = taken;
                    bus.minc_select = taken;
                end
                S_HALT:  bus.oHalted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: per-instruction transaction model predicts
// cycle count, strobe lengths, pulse counts and selects seen during each instruction.
module tb_control_sequencer;

    localparam logic [4:0] OPC_LD = 5'b00000, OPC_ST = 5'b00010, OPC_ADD = 5'b00011,
                           OPC_SUB = 5'b00100, OPC_AND = 5'b00101, OPC_OR = 5'b00110,
                           OPC_ADDI = 5'b01100, OPC_MUL = 5'b01111, OPC_DIV = 5'b10000,
                           OPC_BEQ = 5'b10011, OPC_JR = 5'b10100, OPC_JAL = 5'b10101,
                           OPC_NOP = 5'b11010, OPC_HALT = 5'b11011, OPC_BAD = 5'b11111;

    logic iClk;
    logic nRst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [4:0] ops [14];

    control_sequencer_if bus ();

    control_sequencer dut (
        .iClk (iClk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] out_vec();
        return {bus.ir_enable, bus.ra_enable, bus.rb_enable, bus.rz0_enable, bus.rz1_enable,
                bus.rm_enable, bus.ry_enable, bus.rpc_enable, bus.rpc_temp_enable,
                bus.mb_select, bus.minc_select, bus.mpc_select, bus.my_select, bus.mc_select,
                bus.rf_write, bus.alu_control, bus.mem_read, bus.mem_write,
                bus.instruction_mem_read};
    endfunction

    // Called just after a falling edge with the DUT in FETCH; returns on the falling edge
    // where the next FETCH is visible.
    task automatic run_instr(input logic [31:0] irw, input int fw, input int mw, input logic z);
        logic [4:0] op;
        int base, wr, mcx, myx, rz0, rz1, rm, mrx, mwx, jump, tk, alu;
        int cyc, imr_n, mr_n, mw_n, irn, rf_n, ry_n, rpc_n, rpc_pc, minc_n;
        int rz0_n, rz1_n, rm_n, dec_n, clash, flags, mc_seen, my_seen;
        logic [3:0] alu_or;
        logic left, done;

        op = irw[31:27];
        base = 2; wr = 0; mcx = 0; myx = 0; rz0 = 0; rz1 = 0; rm = 0;
        mrx = 0; mwx = 0; jump = 0; tk = 0;
        case (op)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_MUL, OPC_DIV: begin
                base = 5; wr = 1; mcx = 1; rz0 = 1; rz1 = 1;
            end
            OPC_ADDI: begin base = 5; wr = 1; rz0 = 1; end
            OPC_LD:   begin base = 5 + mw; wr = 1; myx = 2; rz0 = 1; mrx = mw + 1; end
            OPC_ST:   begin base = 4 + mw; rz0 = 1; rm = 1; mwx = mw + 1; end
            OPC_BEQ:  begin base = 4; tk = int'(z); end
            OPC_JR:   begin base = 3; jump = 1; end
            OPC_JAL:  begin base = 5; wr = 1; mcx = 2; myx = 3; jump = 1; end
            default:  base = 2;
        endcase
        case (op)
            OPC_SUB, OPC_BEQ: alu = 1;
            OPC_OR:  alu = 2;
            OPC_AND: alu = 3;
            OPC_DIV: alu = 4;
            OPC_MUL: alu = 5;
            default: alu = 0;
        endcase

        cyc = 0; imr_n = 0; mr_n = 0; mw_n = 0; irn = 0; rf_n = 0; ry_n = 0; rpc_n = 0;
        rpc_pc = 0; minc_n = 0; rz0_n = 0; rz1_n = 0; rm_n = 0; dec_n = 0; clash = 0;
        flags = 0; mc_seen = 0; my_seen = 0; alu_or = 4'd0; left = 1'b0; done = 1'b0;

        bus.ir = irw;
        bus.alu_zero_flag = z;
        #1 check("fetch_entry", bus.instruction_mem_read, 1);
        while (!done && cyc < 60) begin
            bus.iInstrReady = bus.instruction_mem_read ? (imr_n >= fw) : 1'($urandom_range(0, 1));
            bus.iMemReady   = (bus.mem_read || bus.mem_write) ? ((mr_n + mw_n) >= mw)
                                                               : 1'($urandom_range(0, 1));
            #1;
            cyc++;
            if (!bus.instruction_mem_read) left = 1'b1;
            imr_n  += int'(bus.instruction_mem_read);
            mr_n   += int'(bus.mem_read);
            mw_n   += int'(bus.mem_write);
            irn    += int'(bus.ir_enable);
            rz0_n  += int'(bus.rz0_enable);
            rz1_n  += int'(bus.rz1_enable);
            rm_n   += int'(bus.rm_enable);
            dec_n  += int'(bus.ra_enable && bus.rb_enable && bus.rpc_temp_enable);
            clash  += int'(bus.mem_read && bus.mem_write);
            flags  += int'(bus.oHalted || bus.oFault);
            alu_or |= bus.alu_control;
            if (bus.rf_write)  begin rf_n++; mc_seen = int'(bus.mc_select); end
            if (bus.ry_enable) begin ry_n++; my_seen = int'(bus.my_select); end
            if (bus.rpc_enable) begin
                rpc_n++;
                rpc_pc += int'(bus.mpc_select);
                minc_n += int'(bus.minc_select);
            end
            @(negedge iClk);
            if (left && bus.instruction_mem_read) done = 1'b1;
        end

        check("instr_done", done, 1);
        check("cycles", cyc, base + fw);
        check("imem_strobe_cycles", imr_n, fw + 1);
        check("ir_enable_pulses", irn, 1);
        check("decode_pulses", dec_n, 1);
        check("mem_read_cycles", mr_n, mrx);
        check("mem_write_cycles", mw_n, mwx);
        check("rz0_pulses", rz0_n, rz0);
        check("rz1_pulses", rz1_n, rz1);
        check("rm_pulses", rm_n, rm);
        check("rf_write_pulses", rf_n, wr);
        check("ry_pulses", ry_n, wr);
        if (wr != 0) begin
            check("mc_select_at_write", mc_seen, mcx);
            check("my_select_at_ry", my_seen, myx);
        end
        check("rpc_pulses", rpc_n, 1 + jump + tk);
        check("rpc_pc_adder_pulses", rpc_pc, 1 + tk);
        check("minc_c_pulses", minc_n, tk);
        check("alu_control", alu_or, alu);
        check("mem_rw_clash", clash, 0);
        check("halt_fault_flags", flags, 0);
    endtask

    task automatic run_halt(input logic [4:0] op, input logic exp_fault);
        int bad;
        bus.ir = {op, 27'($urandom)};
        bus.iInstrReady = 1'b1;
        @(negedge iClk);
        #1 check("decode_fault_not_yet", bus.oFault, 0);
        @(negedge iClk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            bus.iInstrReady = 1'($urandom_range(0, 1));
            bus.iMemReady   = 1'($urandom_range(0, 1));
            #1;
            if (out_vec() != 24'd0 || !bus.oHalted || bus.oFault != exp_fault) bad++;
            @(negedge iClk);
        end
        check("halt_halted", bus.oHalted, 1);
        check("halt_fault", bus.oFault, exp_fault);
        check("halt_quiet_cycles", bad, 0);
        #2 nRst = 1'b0;
        #1 check("halt_reset_clears", {bus.oHalted, bus.oFault}, 0);
        @(negedge iClk);
        nRst = 1'b1;
        #1 check("halt_reset_fetch", bus.instruction_mem_read, 1);
    endtask

    initial begin
        ops = '{OPC_LD, OPC_ST, OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ADDI,
                OPC_MUL, OPC_DIV, OPC_BEQ, OPC_JR, OPC_JAL, OPC_NOP, OPC_ADD};
        nRst = 1'b0;
        bus.ir = 32'h0;
        bus.alu_zero_flag = 1'b0;
        bus.iInstrReady = 1'b1;
        bus.iMemReady = 1'b1;
        repeat (2) @(negedge iClk);
        #1;
        check("reset_outputs", out_vec(), 0);
        check("reset_flags", {bus.oHalted, bus.oFault}, 0);
        @(negedge iClk);
        nRst = 1'b1;
        #1 check("release_fetch", bus.instruction_mem_read, 1);

        run_instr(32'h18998000, 0, 0, 1'b0);
        run_instr({OPC_LD, 27'h0123456}, 0, 3, 1'b0);
        run_instr({OPC_BEQ, 27'h0}, 0, 0, 1'b1);
        run_instr({OPC_BEQ, 27'h0}, 0, 0, 1'b0);
        run_instr({OPC_JAL, 27'h0}, 1, 0, 1'b0);
        run_instr({OPC_NOP, 27'h0}, 0, 0, 1'b0);

        // Reset during a store wait abandons the write at once.
        bus.ir = {OPC_ST, 27'h0};
        bus.iInstrReady = 1'b1;
        bus.iMemReady = 1'b0;
        for (int i = 0; i < 10 && !bus.mem_write; i++) @(negedge iClk);
        check("st_wait_strobe", bus.mem_write, 1);
        @(negedge iClk);
        #2 nRst = 1'b0;
        #1 check("st_reset_strobe_drop", bus.mem_write, 0);
        check("st_reset_outputs", out_vec(), 0);
        @(negedge iClk);
        nRst = 1'b1;
        #1 check("st_reset_fetch", bus.instruction_mem_read, 1);

        for (int n = 0; n < 40; n++)
            run_instr({ops[$urandom_range(0, 13)], 27'($urandom)},
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));

        run_halt(OPC_HALT, 1'b0);
        run_instr({OPC_SUB, 27'h0}, 0, 0, 1'b0);
        run_halt(OPC_BAD, 1'b1);
        run_instr({OPC_ST, 27'h0}, 2, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
